// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the PC fetch sequencer: controller states,
// PC width/increment, default reset PC and small address helpers.
package pc_ctrl_pkg;

  localparam int PC_WIDTH = 32;
  localparam logic [0:PC_WIDTH-1] PC_INC = 32'd4;
  localparam logic [0:PC_WIDTH-1] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  // True when the address lies on a 4-byte word boundary (bit 31 is the LSB).
  function automatic logic word_aligned(input logic [0:PC_WIDTH-1] addr);
    return (addr[30:31] == 2'b00);
  endfunction

  // Clears the word offset so a loaded target is always word aligned.
  function automatic logic [0:PC_WIDTH-1] align_down(input logic [0:PC_WIDTH-1] addr);
    logic [0:PC_WIDTH-1] res;
    res        = addr;
    res[30:31] = 2'b00;
    return res;
  endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry instruction/PC buffer between fetch and decode.
// Priority: reset, flush, write, then drain on rd_ready.
module fetch_out_buf
  import pc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [0:PC_WIDTH-1] wr_data,
  input  logic [0:PC_WIDTH-1] wr_pc,
  input  logic                flush,
  input  logic                rd_ready,
  output logic                valid,
  output logic [0:PC_WIDTH-1] data,
  output logic [0:PC_WIDTH-1] pc
);

  logic                valid_r;
  logic [0:PC_WIDTH-1] data_r;
  logic [0:PC_WIDTH-1] pc_r;

  // Buffer occupancy and payload update.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= 32'h0000_0000;
      pc_r    <= 32'h0000_0000;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (wr_en) begin
      valid_r <= 1'b1;
      data_r  <= wr_data;
      pc_r    <= wr_pc;
    end else if (rd_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;
  assign pc    = pc_r;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC fetch sequencer: holds the architectural PC, issues one instruction
// memory request at a time and hands fetched words to decode through a
// one-entry buffer. Redirects squash wrong-path fetches; halt is sticky.
// Optional feature macro: PC_FETCH_ALIGN_CHECK_EN (misaligned redirect
// targets raise a sticky misalign flag and halt instead of being aligned).
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [0:PC_WIDTH-1] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                br_taken,
  input  logic [0:PC_WIDTH-1] br_target,
  input  logic                halt_req,
  output logic                imem_req,
  output logic [0:PC_WIDTH-1] imem_addr,
  input  logic                imem_ack,
  input  logic [0:PC_WIDTH-1] imem_data,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [0:PC_WIDTH-1] instr_out,
  output logic [0:PC_WIDTH-1] instr_pc,
  output logic                halted,
  output logic                misalign
);

  fetch_state_e        state_r;
  fetch_state_e        state_next;
  logic [0:PC_WIDTH-1] pc_r;
  logic [0:PC_WIDTH-1] pc_next;
  logic                squash_r;
  logic                squash_next;
  logic                misalign_r;
  logic                misalign_next;
  logic                req_r;
  logic                halted_r;

  logic                br_live_s;
  logic                bad_tgt_s;
  logic                redirect_s;
  logic                halt_now_s;
  logic [0:PC_WIDTH-1] load_tgt_s;
  logic                buf_wr_s;
  logic                buf_flush_s;
  logic                buf_valid_s;

  // Redirects are ignored once halted.
  assign br_live_s = br_taken && (state_r != HALT);

`ifdef PC_FETCH_ALIGN_CHECK_EN
  assign bad_tgt_s  = br_live_s && !word_aligned(br_target);
  assign load_tgt_s = br_target;
`else
  assign bad_tgt_s  = 1'b0;
  assign load_tgt_s = align_down(br_target);
`endif

  // A misaligned target never loads the PC; it behaves like a halt request.
  assign redirect_s = br_live_s && !bad_tgt_s;
  assign halt_now_s = halt_req || misalign_r || bad_tgt_s;

  // Next-state, next-PC, squash and buffer control.
  always_comb begin
    state_next    = state_r;
    pc_next       = pc_r;
    squash_next   = squash_r;
    misalign_next = misalign_r || bad_tgt_s;
    buf_wr_s      = 1'b0;
    buf_flush_s   = br_live_s;

    if (redirect_s) begin
      pc_next = load_tgt_s;
    end else begin
      pc_next = pc_r;
    end

    case (state_r)
      BOOT: begin
        if (halt_now_s) begin
          state_next = HALT;
        end else begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          // Request retires; keep data only if still on the right path.
          squash_next = 1'b0;
          if (!br_live_s && !squash_r) begin
            buf_wr_s = 1'b1;
            pc_next  = pc_r + PC_INC;
          end else begin
            buf_wr_s = 1'b0;
          end
          if (halt_now_s) begin
            state_next = HALT;
          end else begin
            state_next = WAIT;
          end
        end else begin
          // The in-flight request must complete; mark it wrong-path on redirect.
          if (br_live_s) begin
            squash_next = 1'b1;
          end else begin
            squash_next = squash_r;
          end
          state_next = FETCH;
        end
      end
      WAIT: begin
        if (halt_now_s) begin
          state_next = HALT;
        end else if (!buf_valid_s || instr_ready || br_live_s) begin
          state_next = FETCH;
        end else begin
          state_next = WAIT;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // Architectural state and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= BOOT;
      pc_r       <= RESET_PC;
      squash_r   <= 1'b0;
      misalign_r <= 1'b0;
      req_r      <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_next;
      pc_r       <= pc_next;
      squash_r   <= squash_next;
      misalign_r <= misalign_next;
      req_r      <= (state_next == FETCH);
      halted_r   <= (state_next == HALT);
    end
  end

  fetch_out_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (buf_wr_s),
    .wr_data  (imem_data),
    .wr_pc    (pc_r),
    .flush    (buf_flush_s),
    .rd_ready (instr_ready),
    .valid    (buf_valid_s),
    .data     (instr_out),
    .pc       (instr_pc)
  );

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign instr_valid = buf_valid_s;
  assign halted      = halted_r;

`ifdef PC_FETCH_ALIGN_CHECK_EN
  assign misalign = misalign_r;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a per-cycle vector table for the
// zero-wait streaming case (plus a second instance with RESET_PC near the
// top of the address space), then hand-written multi-cycle sequences.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_taken = 1'b0;
  logic [0:31] br_target = 32'h0;
  logic        halt_req = 1'b0;
  logic        imem_req;
  logic [0:31] imem_addr;
  logic        imem_ack;
  logic [0:31] imem_data = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [0:31] instr_out;
  logic [0:31] instr_pc;
  logic        halted;
  logic        misalign;

  logic        ack_m = 1'b0;
  logic        stray_ack = 1'b0;
  int          lat = 0;
  int          mem_cnt = 0;
  int          ack_count = 0;

  logic        w_req;
  logic [0:31] w_addr;
  logic        w_valid;
  logic [0:31] w_out;
  logic [0:31] w_pc;
  logic        w_halted;
  logic        w_mis;
  logic [0:31] w_data = 32'h0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_ack = ack_m | stray_ack;

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst), .br_taken(br_taken), .br_target(br_target),
    .halt_req(halt_req), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_out(instr_out), .instr_pc(instr_pc),
    .halted(halted), .misalign(misalign)
  );

  pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .br_taken(1'b0), .br_target(32'h0),
    .halt_req(1'b0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_req), .imem_data(w_data), .instr_valid(w_valid),
    .instr_ready(1'b1), .instr_out(w_out), .instr_pc(w_pc),
    .halted(w_halted), .misalign(w_mis)
  );

  function automatic logic [0:31] mem_word(input logic [0:31] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory responder: acks after 'lat' extra request cycles, data derived from address.
  always @(negedge clk) begin
    if (imem_req) begin
      if (mem_cnt == lat) begin
        ack_m     = 1'b1;
        imem_data = mem_word(imem_addr);
        mem_cnt   = 0;
        ack_count = ack_count + 1;
      end else begin
        ack_m   = 1'b0;
        mem_cnt = mem_cnt + 1;
      end
    end else begin
      ack_m   = 1'b0;
      mem_cnt = 0;
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [0:31] act, input logic [0:31] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Leaves the bench at the negedge where rst drops (BOOT cycle).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    br_taken = 1'b0;
    halt_req = 1'b0;
    stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rdy;
    logic        req;
    logic [0:31] addr;
    logic        vld;
    logic [0:31] ipc;
    logic        wreq;
    logic [0:31] waddr;
  } vec_t;

  vec_t tbl[9];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int base;
    int got;

    tbl[0] = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFF8};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8};
    tbl[2] = '{1'b1, 1'b0, 32'h0000_0004, 1'b1, 32'h0, 1'b0, 32'hFFFF_FFFC};
    tbl[3] = '{1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_0008, 1'b1, 32'h4, 1'b0, 32'h0000_0000};
    tbl[5] = '{1'b1, 1'b1, 32'h0000_0008, 1'b0, 32'h0, 1'b1, 32'h0000_0000};
    tbl[6] = '{1'b1, 1'b0, 32'h0000_000C, 1'b1, 32'h8, 1'b0, 32'h0000_0004};
    tbl[7] = '{1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0, 1'b1, 32'h0000_0004};
    tbl[8] = '{1'b1, 1'b0, 32'h0000_0010, 1'b1, 32'hC, 1'b0, 32'h0000_0008};

    // ---- Zero-wait streaming, one vector per cycle from the BOOT cycle on
    lat = 0;
    instr_ready = 1'b1;
    do_reset();
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_misalign", misalign, 1'b0);
    for (int i = 0; i < 9; i++) begin
      instr_ready = tbl[i].rdy;
      chk1($sformatf("stream_req[%0d]", i), imem_req, tbl[i].req);
      chk32($sformatf("stream_addr[%0d]", i), imem_addr, tbl[i].addr);
      chk1($sformatf("stream_valid[%0d]", i), instr_valid, tbl[i].vld);
      if (tbl[i].vld) begin
        chk32($sformatf("stream_ipc[%0d]", i), instr_pc, tbl[i].ipc);
        chk32($sformatf("stream_iout[%0d]", i), instr_out, mem_word(tbl[i].ipc));
      end
      chk1($sformatf("wrap_req[%0d]", i), w_req, tbl[i].wreq);
      chk32($sformatf("wrap_addr[%0d]", i), w_addr, tbl[i].waddr);
      @(negedge clk);
    end

    // ---- Redirect while a request is outstanding (ack 3 cycles later)
    lat = 3;
    do_reset();
    base = ack_count;
    @(negedge clk);
    chk1("br_req_before", imem_req, 1'b1);
    br_taken = 1'b1;
    br_target = 32'h0000_0100;
    @(negedge clk);
    br_taken = 1'b0;
    chk32("br_addr_next", imem_addr, 32'h0000_0100);
    chk1("br_req_held", imem_req, 1'b1);
    repeat (3) @(negedge clk);
    chk1("br_dropped_valid", instr_valid, 1'b0);
    chk1("br_dropped_req", imem_req, 1'b0);
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (instr_valid) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk1("br_valid_seen", got[0], 1'b1);
    chk32("br_acks_before_valid", ack_count - base, 32'd2);
    chk32("br_ipc", instr_pc, 32'h0000_0100);
    chk32("br_iout", instr_out, mem_word(32'h0000_0100));
    @(negedge clk);
    chk32("br_next_addr", imem_addr, 32'h0000_0104);

    // ---- Reset in the middle of a request, then a stray ack in BOOT
    chk1("mid_req_active", imem_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk1("mid_rst_req", imem_req, 1'b0);
    chk32("mid_rst_addr", imem_addr, 32'h0);
    chk1("mid_rst_valid", instr_valid, 1'b0);
    chk32("mid_rst_ipc", instr_pc, 32'h0);
    chk32("mid_rst_iout", instr_out, 32'h0);
    chk1("mid_rst_halted", halted, 1'b0);
    rst = 1'b0;
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    chk1("stray_ack_valid", instr_valid, 1'b0);
    chk32("stray_ack_addr", imem_addr, 32'h0);
    chk1("stray_ack_req", imem_req, 1'b1);

    // ---- Decode stalls 5 cycles: one entry held, no new request
    lat = 0;
    instr_ready = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk1($sformatf("stall_valid[%0d]", k), instr_valid, 1'b1);
      chk32($sformatf("stall_ipc[%0d]", k), instr_pc, 32'h0);
      chk1($sformatf("stall_req[%0d]", k), imem_req, 1'b0);
      @(negedge clk);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    chk1("stall_resume_req", imem_req, 1'b1);
    chk32("stall_resume_addr", imem_addr, 32'h0000_0004);
    chk1("stall_resume_valid", instr_valid, 1'b0);
    @(negedge clk);
    chk1("stall_next_valid", instr_valid, 1'b1);
    chk32("stall_next_ipc", instr_pc, 32'h0000_0004);
    chk32("stall_next_iout", instr_out, mem_word(32'h0000_0004));

    // ---- Halt during an outstanding request (ack on the 3rd request cycle)
    lat = 2;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    halt_req = 1'b1;
    @(negedge clk);
    chk1("halt_not_yet", halted, 1'b0);
    @(negedge clk);
    halt_req = 1'b0;
    chk1("halt_set", halted, 1'b1);
    chk1("halt_buf_valid", instr_valid, 1'b1);
    chk32("halt_buf_ipc", instr_pc, 32'h0);
    chk32("halt_buf_iout", instr_out, mem_word(32'h0));
    chk1("halt_req_low", imem_req, 1'b0);
    @(negedge clk);
    chk1("halt_drained", instr_valid, 1'b0);
    br_taken = 1'b1;
    br_target = 32'h0000_0200;
    @(negedge clk);
    br_taken = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk1($sformatf("halt_stay[%0d]", k), halted, 1'b1);
      chk1($sformatf("halt_noreq[%0d]", k), imem_req, 1'b0);
      chk32($sformatf("halt_pc[%0d]", k), imem_addr, 32'h0000_0004);
      @(negedge clk);
    end

    // ---- Redirect to a misaligned target while waiting on decode
    lat = 0;
    instr_ready = 1'b1;
    do_reset();
    repeat (2) @(negedge clk);
    chk32("mis_pre_ipc", instr_pc, 32'h0);
    br_taken = 1'b1;
    br_target = 32'h0000_0102;
    @(negedge clk);
    br_taken = 1'b0;
`ifdef PC_FETCH_ALIGN_CHECK_EN
    chk1("mis_flag", misalign, 1'b1);
    chk1("mis_halted", halted, 1'b1);
    chk32("mis_pc_kept", imem_addr, 32'h0000_0004);
    chk1("mis_no_req", imem_req, 1'b0);
    @(negedge clk);
    chk1("mis_sticky", misalign, 1'b1);
    chk1("mis_flushed", instr_valid, 1'b0);
`else
    chk1("mis_flag", misalign, 1'b0);
    chk1("mis_halted", halted, 1'b0);
    chk32("mis_aligned_addr", imem_addr, 32'h0000_0100);
    chk1("mis_req", imem_req, 1'b1);
    @(negedge clk);
    chk1("mis_valid", instr_valid, 1'b1);
    chk32("mis_ipc", instr_pc, 32'h0000_0100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
